// File: rtl/rbz_spi_master.sv
// SPI mode 0 register-frame feeder for the raycaster register port.
// Optionally holds each frame until the next vertical-blank rising edge.
module rbz_spi_master #(
  parameter int DATA_W = 80,
  parameter int DIV    = 2,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sync_vblank,
  input  logic              i_vblank,
  output logic              o_ss_n,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int LW = (CW > 7) ? CW : 7;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAITV,
    SHIFT_LO,
    SHIFT_HI,
    TAIL,
    GAPW
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     bits_q, bits_d;
  logic [DW-1:0]     div_q, div_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              vb_prev_q, vb_prev_d;
  logic              ss_n_q, ss_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LW-1:0]     len_w;
  logic [LW-1:0]     len_c;
  logic [DATA_W-1:0] shifted;
  logic              div_end;
  logic              gap_end;
  logic              vb_rise;

  assign len_w   = LW'(i_len);
  assign len_c   = (len_w > LW'(DATA_W)) ? LW'(DATA_W) : len_w;
  assign shifted = sreg_q << 1;
  assign div_end = (div_q == DW'(DIV - 1));
  assign gap_end = (gap_q == GW'(GAP - 1));
  assign vb_rise = i_vblank && !vb_prev_q;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bits_d    = bits_q;
    div_d     = div_q;
    gap_d     = gap_q;
    vb_prev_d = i_vblank;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_valid) begin
          busy_d = 1'b1;
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            sreg_d = i_data;
            bits_d = CW'(len_c);
            div_d  = '0;
            if (i_sync_vblank) begin
              state_d = WAITV;
            end else begin
              state_d = SHIFT_LO;
              ss_n_d  = 1'b0;
              mosi_d  = i_data[DATA_W-1];
            end
          end
        end
      end

      WAITV: begin
        // vblank already high at accept must fall and rise again
        if (vb_rise) begin
          state_d = SHIFT_LO;
          ss_n_d  = 1'b0;
          mosi_d  = sreg_q[DATA_W-1];
          div_d   = '0;
        end
      end

      SHIFT_LO: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          sreg_d = shifted;
          bits_d = bits_q - 1'b1;
          if (bits_q > CW'(1)) begin
            state_d = SHIFT_LO;
            mosi_d  = shifted[DATA_W-1];
          end else begin
            state_d = TAIL;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      TAIL: begin
        if (div_end) begin
          div_d  = '0;
          gap_d  = '0;
          ss_n_d = 1'b1;
          mosi_d = 1'b0;
          if (GAP == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAPW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAPW: begin
        if (gap_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bits_q    <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      vb_prev_q <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bits_q    <= bits_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      vb_prev_q <= vb_prev_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_ready = (state_q == IDLE) && !reset;
  assign o_ss_n  = ss_n_q;
  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rbz_spi_master.sv
// Bench for rbz_spi_master: frame table plus vblank, back-to-back
// and mid-frame reset sequences at DIV=2, GAP=2, DATA_W=80.
module tb_rbz_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [6:0]  i_len = '0;
  logic [79:0] i_data = '0;
  logic        i_sync_vblank = 1'b0;
  logic        i_vblank = 1'b0;
  logic        o_ready, o_ss_n, o_sclk, o_mosi, o_busy, o_done;

  rbz_spi_master #(.DATA_W(80), .DIV(2), .GAP(2)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_len(i_len), .i_data(i_data), .i_sync_vblank(i_sync_vblank),
    .i_vblank(i_vblank), .o_ss_n(o_ss_n), .o_sclk(o_sclk),
    .o_mosi(o_mosi), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI line rules, sampled every cycle
  logic p_mosi = 1'b0;
  int   viol = 0;
  always @(negedge clk) begin
    if (o_sclk && (o_mosi !== p_mosi)) viol <= viol + 1;
    if (o_ss_n && o_sclk) viol <= viol + 1;
    p_mosi <= o_mosi;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  len;
    logic [79:0] data;
    int          exp_fall;
    int          exp_rise;
    int          exp_first;
    int          exp_nb;
    logic [79:0] exp_cap;
    int          exp_done;
    logic        exp_ready1;
  } vec_t;

  vec_t vecs[6];

  int          r_fall, r_rise, r_first, r_nb, r_done;
  logic [79:0] r_cap;
  logic        r_busy1, r_ready1, r_rdone, r_busy_after;

  // Starts at the negedge of cycle 1 relative to the frame start
  task automatic watch(input int budget);
    logic ps;
    logic seen_low;
    r_fall = 0; r_rise = 0; r_first = 0; r_nb = 0; r_done = -1;
    r_cap = '0; r_busy1 = 0; r_ready1 = 0; r_rdone = 0;
    r_busy_after = 1;
    ps = 0; seen_low = 0;
    for (int c = 1; c <= budget; c++) begin
      if (c == 1) begin
        r_busy1  = o_busy;
        r_ready1 = o_ready;
      end
      if (!o_ss_n && !seen_low) begin
        seen_low = 1;
        r_fall   = c;
      end
      if (o_ss_n && seen_low && r_rise == 0) r_rise = c;
      if (o_sclk && !ps) begin
        r_nb++;
        r_cap = {r_cap[78:0], o_mosi};
        if (r_first == 0) r_first = c;
      end
      ps = o_sclk;
      if (o_done) begin
        r_done  = c;
        r_rdone = o_ready;
        @(negedge clk);
        r_busy_after = o_busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [6:0] len, input logic [79:0] d,
                           input int budget);
    int w;
    w = 0;
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    i_valid = 1; i_len = len; i_data = d; i_sync_vblank = 0;
    @(negedge clk);
    i_valid = 0;
    watch(budget);
  endtask

  logic [79:0] d1, d2;
  logic        quiet;
  int          phase, gap;
  logic        sent, seen;

  initial begin
    d1 = 80'hDEAD_BEEF_0123_4567_89AB;
    d2 = 80'h5A5A_C3C3_0F0F_F0F0_1234;
    vecs[0] = '{7'd8,   80'hA5 << 72, 1, 35,  3, 8,  80'hA5,  37,  1'b0};
    vecs[1] = '{7'd80,  d1,           1, 323, 3, 80, d1,      325, 1'b0};
    vecs[2] = '{7'd74,  d1,           1, 299, 3, 74, d1 >> 6, 301, 1'b0};
    vecs[3] = '{7'd100, d2,           1, 323, 3, 80, d2,      325, 1'b0};
    vecs[4] = '{7'd0,   d1,           0, 0,   0, 0,  80'h0,   1,   1'b1};
    vecs[5] = '{7'd1,   80'h1 << 79,  1, 7,   3, 1,  80'h1,   9,   1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_ss_n", o_ss_n, 1);
    chk("rst_sclk", o_sclk, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", o_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].len, vecs[i].data, 600);
      chk($sformatf("v%0d_done_cyc", i), r_done, vecs[i].exp_done);
      chk($sformatf("v%0d_ss_fall", i), r_fall, vecs[i].exp_fall);
      chk($sformatf("v%0d_ss_rise", i), r_rise, vecs[i].exp_rise);
      chk($sformatf("v%0d_first_sclk", i), r_first, vecs[i].exp_first);
      chk($sformatf("v%0d_nbits", i), r_nb, vecs[i].exp_nb);
      chk($sformatf("v%0d_bits", i), r_cap, vecs[i].exp_cap);
      chk($sformatf("v%0d_busy1", i), r_busy1, 1);
      chk($sformatf("v%0d_ready1", i), r_ready1, vecs[i].exp_ready1);
      chk($sformatf("v%0d_ready_done", i), r_rdone, 1);
      chk($sformatf("v%0d_busy_after", i), r_busy_after, 0);
    end

    // vblank sync with vblank already high at accept
    i_vblank = 1;
    repeat (2) @(negedge clk);
    i_valid = 1; i_len = 7'd4; i_data = 80'h9 << 76; i_sync_vblank = 1;
    @(negedge clk);
    i_valid = 0; i_sync_vblank = 0;
    quiet = 1;
    repeat (10) begin
      if (!o_ss_n || o_sclk) quiet = 0;
      @(negedge clk);
    end
    chk("sync_quiet_high", quiet, 1);
    chk("sync_busy_wait", o_busy, 1);
    i_vblank = 0;
    repeat (5) begin
      if (!o_ss_n || o_sclk) quiet = 0;
      @(negedge clk);
    end
    chk("sync_quiet_low", quiet, 1);
    i_vblank = 1;
    chk("sync_ss_at_edge", o_ss_n, 1);
    @(negedge clk);
    chk("sync_ss_fall", o_ss_n, 0);
    chk("sync_first_bit", o_mosi, 1);
    watch(200);
    chk("sync_bits", r_cap, 80'h9);
    chk("sync_ss_rise", r_rise, 19);
    chk("sync_done_cyc", r_done, 21);

    // back-to-back frames queued at the done cycle
    i_valid = 1; i_len = 7'd2; i_data = 80'hC << 76;
    @(negedge clk);
    i_valid = 0;
    phase = 0; gap = 0; sent = 0;
    for (int c = 0; c < 200 && phase < 3; c++) begin
      if (phase == 0 && !o_ss_n) phase = 1;
      else if (phase == 1 && o_ss_n) begin
        phase = 2;
        gap = 1;
      end else if (phase == 2) begin
        if (o_ss_n) gap++;
        else phase = 3;
      end
      if (o_done && !sent) begin
        sent = 1;
        chk("b2b_ready_done", o_ready, 1);
        i_valid = 1; i_len = 7'd2; i_data = 80'h4 << 76;
      end else begin
        i_valid = 0;
      end
      @(negedge clk);
    end
    i_valid = 0;
    chk("b2b_gap", gap, 3);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (o_done) seen = 1;
      @(negedge clk);
    end
    chk("b2b_second_done", seen, 1);

    // reset in the middle of bit 3
    i_valid = 1; i_len = 7'd8; i_data = 80'hFF << 72;
    @(negedge clk);
    i_valid = 0;
    repeat (14) @(negedge clk);
    chk("mid_sclk_bit3", o_sclk, 1);
    chk("mid_mosi_bit3", o_mosi, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_ss_n", o_ss_n, 1);
    chk("mid_rst_sclk", o_sclk, 0);
    chk("mid_rst_mosi", o_mosi, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    reset = 0;
    @(negedge clk);
    chk("mid_ready_after", o_ready, 1);
    quiet = 1;
    repeat (60) begin
      if (o_done || !o_ss_n) quiet = 0;
      @(negedge clk);
    end
    chk("mid_no_done", quiet, 1);

    chk("line_rules", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
